// File: rtl/band_scheduler.sv
// ---------------------------------------------------------------------------
// band_scheduler
//   Shares one arithmetic unit among NBANDS equalizer bands. Each accepted
//   audio sample launches one filter computation per enabled band, in
//   ascending band order. The block steers the coefficient/state bank select,
//   strobes the per-band result register, and pulses completion once every
//   enabled band has been processed. A watchdog aborts a band whose
//   arithmetic result never arrives. Overrun and timeout are sticky flags.
//
//   Optional feature macro: SCHED_PEND_QUEUE_EN
//     defined   : a one-deep pending register holds a sample that arrives
//                 while busy; it is taken up in the DONE cycle.
//     undefined : samples arriving while busy are dropped and flag overrun.
// ---------------------------------------------------------------------------
module band_scheduler #(
    parameter int NBANDS  = 3,
    parameter int BW      = 2,
    parameter int TW      = 6,
    parameter int TIMEOUT = 40
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_datolisto,
    input  logic [NBANDS-1:0] i_band_en,
    input  logic              i_arit_listo,
    input  logic              i_clr_err,
    output logic              o_arit_start,
    output logic [BW-1:0]     o_band_sel,
    output logic [NBANDS-1:0] o_band_we,
    output logic              o_muestra_lista,
    output logic              o_ocupado,
    output logic              o_overrun,
    output logic              o_timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_STORE  = 3'd3,
        S_NEXT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [NBANDS-1:0] r_mask;
    logic [BW-1:0]     r_band_sel;
    logic [TW-1:0]     r_timer;
    logic              r_overrun;
    logic              r_timeout_err;

    logic              w_low_any;
    logic [BW-1:0]     w_low_idx;
    logic              w_up_found;
    logic [BW-1:0]     w_up_idx;
    logic              w_accept;
    logic              w_overrun_evt;
    logic              w_timeout_evt;
    logic              w_timer_last;

    // -----------------------------------------------------------------------
    // Band search helpers
    // -----------------------------------------------------------------------
    assign w_low_any = |i_band_en;

    // Lowest enabled band of the incoming mask: the first band of a new sample
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        w_low_idx = '0;
        for (int i = NBANDS - 1; i >= 0; i--) begin
            if (i_band_en[i]) begin
                w_low_idx = BW'(i);
            end
        end
    end

    // Next enabled band strictly above the current one in the latched mask
    always_comb begin
        w_up_found = 1'b0;
        w_up_idx   = r_band_sel;
        for (int i = NBANDS - 1; i >= 0; i--) begin
            if (r_mask[i] && (i > int'(r_band_sel))) begin
                w_up_found = 1'b1;
                w_up_idx   = BW'(i);
            end
        end
    end

    assign w_timer_last = (r_timer == TW'(TIMEOUT - 1));

    // -----------------------------------------------------------------------
    // Sample acceptance and overrun detection
    // -----------------------------------------------------------------------
`ifdef SCHED_PEND_QUEUE_EN
    logic r_pend;
    logic w_can_accept;

    // DONE behaves like IDLE for acceptance so a held sample starts at once
    assign w_can_accept  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept      = w_can_accept && (i_datolisto || r_pend);
    // Only a strobe that finds the pending slot already occupied is lost
    assign w_overrun_evt = !w_can_accept && i_datolisto && r_pend;

    // One-deep pending sample: filled while busy, drained when accepting
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pend <= 1'b0;
        end else if (w_can_accept) begin
            // Draining the held sample while a fresh strobe arrives re-fills it
            r_pend <= r_pend && i_datolisto;
        end else if (i_datolisto) begin
            r_pend <= 1'b1;
        end
    end
`else
    assign w_accept      = (r_state == S_IDLE) && i_datolisto;
    // Any strobe outside IDLE, DONE included, is a dropped sample
    assign w_overrun_evt = (r_state != S_IDLE) && i_datolisto;
`endif

    // -----------------------------------------------------------------------
    // Controller FSM
    // -----------------------------------------------------------------------

    // State register
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register in the design updates from the same pre-edge values.
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and Moore control pulses
    always_comb begin
        w_state_next    = r_state;
        o_arit_start    = 1'b0;
        o_muestra_lista = 1'b0;
        w_timeout_evt   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_low_any ? S_LAUNCH : S_DONE;
                end
            end
            S_LAUNCH: begin
                o_arit_start = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                // A result on the final watchdog cycle still counts as on time
                if (i_arit_listo) begin
                    w_state_next = S_STORE;
                end else if (w_timer_last) begin
                    w_timeout_evt = 1'b1;
                    w_state_next  = S_NEXT;
                end
            end
            S_STORE: begin
                w_state_next = S_NEXT;
            end
            S_NEXT: begin
                w_state_next = w_up_found ? S_LAUNCH : S_DONE;
            end
            S_DONE: begin
                o_muestra_lista = 1'b1;
                if (w_accept) begin
                    w_state_next = w_low_any ? S_LAUNCH : S_DONE;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // One-hot result-register strobe for the active band during STORE
    always_comb begin
        o_band_we = '0;
        for (int i = 0; i < NBANDS; i++) begin
            o_band_we[i] = (r_state == S_STORE) && (r_band_sel == BW'(i));
        end
    end

    assign o_ocupado     = (r_state != S_IDLE);
    assign o_band_sel    = r_band_sel;
    assign o_overrun     = r_overrun;
    assign o_timeout_err = r_timeout_err;

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------

    // Band mask, active band index and watchdog timer
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mask     <= '0;
            r_band_sel <= '0;
            r_timer    <= '0;
        end else begin
            if (w_accept) begin
                r_mask <= i_band_en;
                // An empty mask keeps the previous band index untouched
                if (w_low_any) begin
                    r_band_sel <= w_low_idx;
                end
            end else if ((r_state == S_NEXT) && w_up_found) begin
                r_band_sel <= w_up_idx;
            end

            if (r_state == S_LAUNCH) begin
                r_timer <= '0;
            end else if (r_state == S_WAIT) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    // Sticky error flags: a same-cycle new error beats the clear request
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_overrun     <= (r_overrun     && !i_clr_err) || w_overrun_evt;
            r_timeout_err <= (r_timeout_err && !i_clr_err) || w_timeout_evt;
        end
    end

endmodule

// File: tb/tb_band_scheduler.sv
// ---------------------------------------------------------------------------
// tb_band_scheduler
//   Directed bench for band_scheduler. Each sample sent pushes the expected
//   launch, band-write and completion events (with their cycle numbers) into
//   scoreboard queues; a monitor pops and compares them as the DUT emits.
//   An arithmetic-unit responder answers arit_start after a chosen latency
//   or withholds the answer for one band.
//   Build with +define+SCHED_PEND_QUEUE_EN to cover the pending-sample mode.
// ---------------------------------------------------------------------------
module tb_band_scheduler;

    localparam int NB  = 3;
    localparam int BWL = 2;
    localparam int TMO = 40;

    logic           clk;
    logic           i_reset;
    logic           i_datolisto;
    logic [NB-1:0]  i_band_en;
    logic           i_arit_listo;
    logic           i_clr_err;
    logic           o_arit_start;
    logic [BWL-1:0] o_band_sel;
    logic [NB-1:0]  o_band_we;
    logic           o_muestra_lista;
    logic           o_ocupado;
    logic           o_overrun;
    logic           o_timeout_err;

    band_scheduler #(
        .NBANDS (NB),
        .BW     (BWL),
        .TW     (6),
        .TIMEOUT(TMO)
    ) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_datolisto    (i_datolisto),
        .i_band_en      (i_band_en),
        .i_arit_listo   (i_arit_listo),
        .i_clr_err      (i_clr_err),
        .o_arit_start   (o_arit_start),
        .o_band_sel     (o_band_sel),
        .o_band_we      (o_band_we),
        .o_muestra_lista(o_muestra_lista),
        .o_ocupado      (o_ocupado),
        .o_overrun      (o_overrun),
        .o_timeout_err  (o_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard
    typedef struct {
        int cyc;
        int band;
    } ev_t;

    ev_t q_launch[$];
    ev_t q_we[$];
    int  q_done[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_starts = 0;
    int n_dones  = 0;
    int n_wes    = 0;

    int d_lat         = 1;
    int withhold_band = -1;
    int exp_tmo_cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: expected event schedule of one accepted sample.
    // p0 is the cycle in which the sample is accepted (cycle 0).
    task automatic expect_sample(input int p0, input logic [NB-1:0] en, input int d);
        int  t;
        ev_t e;
        t = p0 + 1;
        for (int b = 0; b < NB; b++) begin
            if (en[b]) begin
                e.cyc  = t;
                e.band = b;
                q_launch.push_back(e);
                if ((b == withhold_band) || (d > TMO)) begin
                    // WAIT starts with timer 0; the last tolerated cycle is launch+TMO
                    exp_tmo_cyc = t + TMO;
                    t = t + TMO + 2;
                end else begin
                    e.cyc = t + d + 1;
                    q_we.push_back(e);
                    t = t + d + 3;
                end
            end
        end
        q_done.push_back(t);
    endtask

    // Called at a falling edge; returns one cycle later with the strobe low
    task automatic send_sample(input logic [NB-1:0] en, input int d);
        d_lat       = d;
        i_band_en   = en;
        i_datolisto = 1'b1;
        expect_sample(cyc, en, d);
        @(negedge clk);
        i_datolisto = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (o_ocupado && (k < 600)) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_idle"}, o_ocupado, 1'b0);
        check({tag, "_drain"}, q_launch.size() + q_we.size() + q_done.size(), 0);
    endtask

    task automatic clear_errors();
        i_clr_err = 1'b1;
        @(negedge clk);
        i_clr_err = 1'b0;
        @(negedge clk);
    endtask

    // Cycle counter
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Arithmetic-unit responder: one-cycle arit_listo d_lat cycles after start
    initial begin
        int cnt;
        cnt          = 0;
        i_arit_listo = 1'b0;
        forever begin
            @(negedge clk);
            i_arit_listo = 1'b0;
            if (i_reset) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) i_arit_listo = 1'b1;
                end
                if (o_arit_start && (int'(o_band_sel) != withhold_band)) begin
                    cnt = d_lat;
                end
            end
        end
    end

    // Monitor: pops scoreboard entries as the DUT produces events
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (o_arit_start) begin
                n_starts++;
                check("launch_expected", q_launch.size() > 0, 1'b1);
                if (q_launch.size() > 0) begin
                    e = q_launch.pop_front();
                    check("launch_cycle", cyc, e.cyc);
                    check("launch_band_sel", o_band_sel, e.band);
                end
            end
            if (|o_band_we) begin
                n_wes++;
                check("band_we_expected", q_we.size() > 0, 1'b1);
                if (q_we.size() > 0) begin
                    e = q_we.pop_front();
                    check("band_we_cycle", cyc, e.cyc);
                    check("band_we_value", o_band_we, 32'd1 << e.band);
                end
            end
            if (o_muestra_lista) begin
                n_dones++;
                check("muestra_expected", q_done.size() > 0, 1'b1);
                if (q_done.size() > 0) begin
                    check("muestra_cycle", cyc, q_done.pop_front());
                end
            end
        end
    end

    // Absolute time limit
    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "time limit");
    end

    // Directed sequence
    initial begin
        int p0;
        int starts0;
        int dones0;
        int wes0;

        i_reset     = 1'b1;
        i_datolisto = 1'b0;
        i_band_en   = '0;
        i_clr_err   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ocupado", o_ocupado, 1'b0);
        check("rst_arit_start", o_arit_start, 1'b0);
        check("rst_band_we", o_band_we, 3'b000);
        check("rst_muestra", o_muestra_lista, 1'b0);
        check("rst_band_sel", o_band_sel, 2'd0);
        check("rst_overrun", o_overrun, 1'b0);
        check("rst_timeout", o_timeout_err, 1'b0);
        i_reset = 1'b0;
        @(negedge clk);

        // All bands, D=27: done at cycle 91; band_en change while busy ignored
        send_sample(3'b111, 27);
        i_band_en = 3'b000;
        wait_idle("t1");
        check("t1_overrun", o_overrun, 1'b0);
        check("t1_timeout", o_timeout_err, 1'b0);

        // Bands 0 and 2, D=5: band 1 skipped, done at cycle 17
        send_sample(3'b101, 5);
        wait_idle("t2");
        check("t2_band_sel_hold", o_band_sel, 2'd2);

        // Empty mask: no launch, done at cycle 1, busy for cycle 1 only
        starts0 = n_starts;
        send_sample(3'b000, 4);
        check("t3_ocupado_c1", o_ocupado, 1'b1);
        @(negedge clk);
        check("t3_ocupado_c2", o_ocupado, 1'b0);
        check("t3_no_start", n_starts - starts0, 0);
        wait_idle("t3");

        // Result on the last watchdog cycle is still accepted
        send_sample(3'b001, TMO);
        wait_idle("tb_edge_ok");
        check("tb_edge_ok_timeout", o_timeout_err, 1'b0);

        // One cycle later the band is aborted; the late result lands in NEXT
        wes0 = n_wes;
        send_sample(3'b001, TMO + 1);
        wait_idle("tb_edge_late");
        check("tb_edge_late_timeout", o_timeout_err, 1'b1);
        check("tb_edge_late_no_we", n_wes - wes0, 0);
        clear_errors();
        check("tb_edge_late_clr", o_timeout_err, 1'b0);

        // Band 1 withheld: timeout, band 2 still processed; clr vs new error
        withhold_band = 1;
        send_sample(3'b111, 3);
        while (cyc < exp_tmo_cyc) @(negedge clk);
        check("t4_err_before", o_timeout_err, 1'b0);
        i_clr_err = 1'b1;
        @(negedge clk);
        i_clr_err = 1'b0;
        check("t4_err_beats_clr", o_timeout_err, 1'b1);
        wait_idle("t4");
        withhold_band = -1;
        check("t4_sticky", o_timeout_err, 1'b1);
        clear_errors();
        check("t4_cleared", o_timeout_err, 1'b0);

        // Second sample arrives at cycle 10 of a busy sample
        p0 = cyc;
        send_sample(3'b111, 5);
        i_band_en = 3'b010;
        while (cyc < p0 + 10) @(negedge clk);
        i_datolisto = 1'b1;
`ifdef SCHED_PEND_QUEUE_EN
        // Held sample starts in the DONE cycle with band_en sampled there
        expect_sample(p0 + 25, 3'b010, 5);
`endif
        @(negedge clk);
        i_datolisto = 1'b0;
        wait_idle("t5");
`ifdef SCHED_PEND_QUEUE_EN
        check("t5_overrun", o_overrun, 1'b0);
`else
        check("t5_overrun", o_overrun, 1'b1);
`endif
        clear_errors();
        check("t5_cleared", o_overrun, 1'b0);

        // Strobe held into the DONE cycle of an empty-mask sample
        p0          = cyc;
        i_band_en   = 3'b000;
        i_datolisto = 1'b1;
        expect_sample(p0, 3'b000, 1);
`ifdef SCHED_PEND_QUEUE_EN
        expect_sample(p0 + 1, 3'b000, 1);
`endif
        @(negedge clk);
        @(negedge clk);
        i_datolisto = 1'b0;
        wait_idle("t5b");
`ifdef SCHED_PEND_QUEUE_EN
        check("t5b_overrun", o_overrun, 1'b0);
`else
        check("t5b_overrun", o_overrun, 1'b1);
`endif

        // Reset while band 2 is waiting: immediate abort, then clean restart
        p0 = cyc;
        send_sample(3'b111, 20);
        while (cyc < p0 + 50) @(negedge clk);
        check("t6_sel_before", o_band_sel, 2'd2);
        dones0  = n_dones;
        wes0    = n_wes;
        i_reset = 1'b1;
        q_launch.delete();
        q_we.delete();
        q_done.delete();
        @(negedge clk);
        check("t6_ocupado", o_ocupado, 1'b0);
        check("t6_band_sel", o_band_sel, 2'd0);
        check("t6_arit_start", o_arit_start, 1'b0);
        check("t6_flags", {o_overrun, o_timeout_err}, 2'b00);
        @(negedge clk);
        i_reset = 1'b0;
        repeat (30) @(negedge clk);
        check("t6_no_muestra", n_dones - dones0, 0);
        check("t6_no_band_we", n_wes - wes0, 0);
        send_sample(3'b111, 2);
        wait_idle("t6_restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
